// File: rtl/load_board.sv
// Byte-serial ASCII position loader: 64 squares (a8..h1), castle bits, side, en passant file.
// Results commit atomically one cycle after the final byte; outputs hold otherwise.
`ifndef VCHESS_VH
`define VCHESS_VH
`define PIECE_WIDTH 4
`define SIDE_WIDTH (`PIECE_WIDTH*8)
`define BOARD_WIDTH (`PIECE_WIDTH*64)
`define EMPTY_POSN   4'd0
`define WHITE_PAWN   4'd1
`define WHITE_KNIGHT 4'd2
`define WHITE_BISHOP 4'd3
`define WHITE_ROOK   4'd4
`define WHITE_QUEEN  4'd5
`define WHITE_KING   4'd6
`define BLACK_PAWN   4'd9
`define BLACK_KNIGHT 4'd10
`define BLACK_BISHOP 4'd11
`define BLACK_ROOK   4'd12
`define BLACK_QUEEN  4'd13
`define BLACK_KING   4'd14
`endif

module load_board (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [`BOARD_WIDTH-1:0] board,
   output logic [3:0]              castle_mask,
   output logic [3:0]              en_passant_col,
   output logic                    white_to_move,
   output logic                    busy,
   output logic                    load_done,
   output logic                    load_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_SQUARES, S_CASTLE, S_SIDE, S_EP, S_DONE, S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              rank_q, rank_d;
   logic [2:0]              col_q, col_d;
   logic [1:0]              ccnt_q, ccnt_d;
   logic [`BOARD_WIDTH-1:0] board_w_q, board_w_d;
   logic [3:0]              castle_w_q, castle_w_d;
   logic                    side_w_q, side_w_d;
   logic [`BOARD_WIDTH-1:0] board_q, board_d;
   logic [3:0]              castle_q, castle_d;
   logic [3:0]              ep_q, ep_d;
   logic                    wtm_q, wtm_d;
   logic                    in_ready_q, in_ready_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    acc, is_ws;
   logic [4:0]              pc;
   logic [7:0]              idx;
   logic [7:0]              file_off;

   // {valid, piece code}
   function automatic logic [4:0] piece_code(input logic [7:0] c);
      case (c)
         ".":     return {1'b1, `EMPTY_POSN};
         "P":     return {1'b1, `WHITE_PAWN};
         "N":     return {1'b1, `WHITE_KNIGHT};
         "B":     return {1'b1, `WHITE_BISHOP};
         "R":     return {1'b1, `WHITE_ROOK};
         "Q":     return {1'b1, `WHITE_QUEEN};
         "K":     return {1'b1, `WHITE_KING};
         "p":     return {1'b1, `BLACK_PAWN};
         "n":     return {1'b1, `BLACK_KNIGHT};
         "b":     return {1'b1, `BLACK_BISHOP};
         "r":     return {1'b1, `BLACK_ROOK};
         "q":     return {1'b1, `BLACK_QUEEN};
         "k":     return {1'b1, `BLACK_KING};
         default: return 5'b0_0000;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      rank_d     = rank_q;
      col_d      = col_q;
      ccnt_d     = ccnt_q;
      board_w_d  = board_w_q;
      castle_w_d = castle_w_q;
      side_w_d   = side_w_q;
      board_d    = board_q;
      castle_d   = castle_q;
      ep_d       = ep_q;
      wtm_d      = wtm_q;
      error_d    = error_q;
      done_d     = 1'b0;

      acc      = in_valid && in_ready_q;
      is_ws    = (in_data == 8'h20) || (in_data == 8'h09) ||
                 (in_data == 8'h0A) || (in_data == 8'h0D);
      pc       = piece_code(in_data);
      // rank*SIDE_WIDTH + col*PIECE_WIDTH
      idx      = {rank_q, col_q, 2'b00};
      file_off = in_data - 8'h61;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_SQUARES;
               error_d = 1'b0;
               rank_d  = 3'd7;
               col_d   = 3'd0;
               ccnt_d  = 2'd0;
            end
         end
         S_SQUARES: begin
            if (acc && !is_ws) begin
               if (pc[4]) begin
                  board_w_d[idx +: `PIECE_WIDTH] = pc[3:0];
                  if (col_q == 3'd7) begin
                     col_d = 3'd0;
                     if (rank_q == 3'd0) state_d = S_CASTLE;
                     else                rank_d  = rank_q - 3'd1;
                  end else begin
                     col_d = col_q + 3'd1;
                  end
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_CASTLE: begin
            if (acc && !is_ws) begin
               if (in_data == "0" || in_data == "1") begin
                  castle_w_d = {castle_w_q[2:0], in_data[0]};
                  ccnt_d     = ccnt_q + 2'd1;
                  if (ccnt_q == 2'd3) state_d = S_SIDE;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_SIDE: begin
            if (acc && !is_ws) begin
               if (in_data == "w" || in_data == "b") begin
                  side_w_d = (in_data == "w");
                  state_d  = S_EP;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_EP: begin
            if (acc && !is_ws) begin
               if (in_data == "-" || (in_data >= "a" && in_data <= "h")) begin
                  // Commit the whole position in one edge
                  ep_d     = (in_data == "-") ? 4'b0000 : {1'b1, file_off[2:0]};
                  board_d  = board_w_q;
                  castle_d = castle_w_q;
                  wtm_d    = side_w_q;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_SQUARES) || (state_d == S_CASTLE) ||
                   (state_d == S_SIDE)    || (state_d == S_EP);
      busy_d     = in_ready_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rank_q     <= 3'd7;
         col_q      <= 3'd0;
         ccnt_q     <= 2'd0;
         board_w_q  <= '0;
         castle_w_q <= 4'd0;
         side_w_q   <= 1'b1;
         board_q    <= {64{`EMPTY_POSN}};
         castle_q   <= 4'd0;
         ep_q       <= 4'd0;
         wtm_q      <= 1'b1;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rank_q     <= rank_d;
         col_q      <= col_d;
         ccnt_q     <= ccnt_d;
         board_w_q  <= board_w_d;
         castle_w_q <= castle_w_d;
         side_w_q   <= side_w_d;
         board_q    <= board_d;
         castle_q   <= castle_d;
         ep_q       <= ep_d;
         wtm_q      <= wtm_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign board          = board_q;
   assign castle_mask    = castle_q;
   assign en_passant_col = ep_q;
   assign white_to_move  = wtm_q;
   assign busy           = busy_q;
   assign load_done      = done_q;
   assign load_error     = error_q;

endmodule

// File: tb/tb_load_board.sv
// Directed bench for load_board: full loads, whitespace, gaps, errors, reset mid-parse.
module tb_load_board;

   localparam logic [3:0] EMPTY = 4'd0;
   localparam logic [3:0] WP = 4'd1, WN = 4'd2, WB = 4'd3, WR = 4'd4, WQ = 4'd5, WK = 4'd6;
   localparam logic [3:0] BP = 4'd9, BN = 4'd10, BB = 4'd11, BR = 4'd12, BQ = 4'd13, BK = 4'd14;

   logic         clk = 1'b0;
   logic         reset, start, in_valid, in_ready;
   logic [7:0]   in_data;
   logic [255:0] board;
   logic [3:0]   castle_mask, en_passant_col;
   logic         white_to_move, busy, load_done, load_error;

   int checks = 0;
   int failures = 0;
   int stalls = 0;
   int done_cnt = 0;
   int done_snap;

   string start_pos, king_pos;
   logic [255:0] exp_start, exp_king, saved_b;

   load_board dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .board(board),
      .castle_mask(castle_mask), .en_passant_col(en_passant_col),
      .white_to_move(white_to_move), .busy(busy),
      .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load_done) done_cnt <= done_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] code_of(input byte c);
      case (c)
         "P": return WP;  "N": return WN;  "B": return WB;
         "R": return WR;  "Q": return WQ;  "K": return WK;
         "p": return BP;  "n": return BN;  "b": return BB;
         "r": return BR;  "q": return BQ;  "k": return BK;
         default: return EMPTY;
      endcase
   endfunction

   // Dump order: char i is rank 8-i/8, file i%8; rank1/file a lives at bit 0
   function automatic logic [255:0] model_board(input string s);
      logic [255:0] b = '0;
      for (int i = 0; i < 64; i++) begin
         int r = 7 - i / 8;
         int f = i % 8;
         b[(r * 32 + f * 4) +: 4] = code_of(s[i]);
      end
      return b;
   endfunction

   // Called just after a negedge; returns at the negedge after the accepting edge
   task automatic send_byte(input byte b, input bit gaps);
      int n = 0;
      if (gaps && $urandom_range(0, 2) == 0) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      if (!in_ready) stalls++;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_squares(input string s, input bit ws, input bit gaps, input int upto);
      for (int i = 0; i < upto; i++) begin
         send_byte(s[i], gaps);
         if (ws) send_byte((i % 8 == 7) ? 8'h0A : 8'h20, gaps);
      end
   endtask

   task automatic send_tail(input string c, input byte side, input byte ep, input bit gaps);
      for (int i = 0; i < 4; i++) send_byte(c[i], gaps);
      send_byte(side, gaps);
      send_byte(ep, gaps);
   endtask

   initial begin
      start_pos = "rnbqkbnrpppppppp................................PPPPPPPPRNBQKBNR";
      king_pos  = "............................................................K...";
      exp_start = model_board(start_pos);
      exp_king  = model_board(king_pos);

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_board", board, 256'd0);
      check("rst_castle", castle_mask, 4'd0);
      check("rst_ep", en_passant_col, 4'd0);
      check("rst_wtm", white_to_move, 1'b1);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", load_done, 1'b0);
      check("rst_error", load_error, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // Start position with whitespace between every square
      do_start();
      check("t1_busy", busy, 1'b1);
      send_byte(8'h09, 1'b0);
      send_byte(8'h0D, 1'b0);
      send_squares(start_pos, 1'b1, 1'b0, 64);
      send_tail("1111", "w", "-", 1'b0);
      check("t1_done_pulse", load_done, 1'b1);
      check("t1_board", board, exp_start);
      check("t1_castle", castle_mask, 4'b1111);
      check("t1_wtm", white_to_move, 1'b1);
      check("t1_ep", en_passant_col, 4'b0000);
      @(negedge clk);
      check("t1_done_one_cycle", load_done, 1'b0);
      check("t1_busy_after", busy, 1'b0);

      // Gap-free, no whitespace
      do_start();
      stalls = 0;
      send_squares(start_pos, 1'b0, 1'b0, 64);
      send_tail("0101", "b", "e", 1'b0);
      check("t2_no_stalls", stalls, 0);
      check("t2_done_pulse", load_done, 1'b1);
      check("t2_board", board, exp_start);
      check("t2_castle", castle_mask, 4'b0101);
      check("t2_wtm", white_to_move, 1'b0);
      check("t2_ep", en_passant_col, 4'b1100);
      @(negedge clk);

      // Invalid byte at square 20: no commit, sticky error
      do_start();
      done_snap = done_cnt;
      send_squares(king_pos, 1'b0, 1'b0, 20);
      send_byte("x", 1'b0);
      check("t3_error", load_error, 1'b1);
      check("t3_in_ready", in_ready, 1'b0);
      check("t3_busy", busy, 1'b0);
      check("t3_board_held", board, exp_start);
      check("t3_castle_held", castle_mask, 4'b0101);
      check("t3_ep_held", en_passant_col, 4'b1100);
      repeat (3) @(negedge clk);
      #1;
      check("t3_no_done", done_cnt, done_snap);
      check("t3_error_sticky", load_error, 1'b1);
      @(negedge clk);
      do_start();
      check("t3_error_cleared", load_error, 1'b0);
      check("t3_busy_restart", busy, 1'b1);

      // Random gaps plus a start pulse mid-parse, on the parse just started
      send_squares(start_pos, 1'b0, 1'b1, 30);
      do_start();
      check("t4_start_ignored", busy, 1'b1);
      for (int i = 30; i < 64; i++) send_byte(start_pos[i], 1'b1);
      send_tail("0101", "b", "e", 1'b1);
      check("t4_done_pulse", load_done, 1'b1);
      check("t4_board", board, exp_start);
      check("t4_castle", castle_mask, 4'b0101);
      check("t4_wtm", white_to_move, 1'b0);
      check("t4_ep", en_passant_col, 4'b1100);
      @(negedge clk);

      // Reset at square 40
      do_start();
      send_squares(king_pos, 1'b0, 1'b0, 40);
      reset = 1'b0;
      #1;
      check("t5_rst_board", board, 256'd0);
      check("t5_rst_castle", castle_mask, 4'd0);
      check("t5_rst_wtm", white_to_move, 1'b1);
      check("t5_rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_start();
      send_squares(start_pos, 1'b0, 1'b0, 64);
      send_tail("1111", "w", "-", 1'b0);
      check("t5_reload_board", board, exp_start);
      check("t5_reload_castle", castle_mask, 4'b1111);
      check("t5_reload_done", load_done, 1'b1);
      @(negedge clk);

      // Lone white king on e1
      do_start();
      send_squares(king_pos, 1'b0, 1'b0, 64);
      send_tail("0000", "w", "-", 1'b0);
      saved_b = board;
      check("t6_e1_field", saved_b[19:16], WK);
      check("t6_board", board, exp_king);
      check("t6_board_literal", board, 256'h60000);
      check("t6_castle", castle_mask, 4'b0000);
      check("t6_wtm", white_to_move, 1'b1);
      check("t6_ep", en_passant_col, 4'b0000);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_board.md
Name: load_board

Overview:
- Parses a byte-serial ASCII position description into the packed board vector and side state used by the move generator.
- Inverse of the board text dump: 64 piece characters in dump order (rank 8 down to rank 1, file a to h), then castle bits, side to move, and en passant file.
- Sits between the host/UART byte stream and the board-state registers. Results are committed atomically on success only.

Parameters:
- None. Widths come from `BOARD_WIDTH, `SIDE_WIDTH and `PIECE_WIDTH in vchess.vh.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a new parse; honoured only in IDLE, ERROR or DONE
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- board  out  `BOARD_WIDTH  committed board, same packing as the move generator
- castle_mask  out  4  committed castle bits
- en_passant_col  out  4  bit 3 = valid, bits 2:0 = file (a=0)
- white_to_move  out  1  committed side to move
- busy  out  1  high in any parsing state
- load_done  out  1  one-cycle pulse on commit
- load_error  out  1  sticky until the next accepted start

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - board = `EMPTY_POSN in all 64 squares.
  - castle_mask=0, en_passant_col=0, white_to_move=1.
  - in_ready, busy, load_done and load_error all 0.
- States: IDLE, SQUARES, CASTLE, SIDE, EP, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Go to SQUARES; clear load_error.
  - Working index = square a8 (bit offset `SIDE_WIDTH*7), col=0, castle count=0.
  - The working board is not cleared, because every square is overwritten.
- in_ready = 1 in SQUARES, CASTLE, SIDE and EP; 0 otherwise. Only accepted bytes advance state.
- Whitespace is accepted and ignored in every parsing state: 0x20, 0x09, 0x0A, 0x0D.
- SQUARES:
  - Valid characters: . P R N B K Q p r n b k q. Map each to its `EMPTY_POSN / `WHITE_* / `BLACK_* code and write it at the working index.
  - After a write, index += `PIECE_WIDTH and col++.
  - At col==7: col=0 and index = row_start - `SIDE_WIDTH.
  - The 64th square (h1, offset `SIDE_WIDTH - `PIECE_WIDTH) moves to CASTLE.
- CASTLE:
  - Accepts four '0'/'1' characters, MSB first, into the working castle_mask.
  - After the fourth character, go to SIDE.
- SIDE:
  - 'w' sets working side=1; 'b' sets it to 0.
  - Then go to EP.
- EP:
  - '-' gives working ep=4'b0000; 'a'..'h' gives {1'b1, file}.
  - Then go to DONE.
- DONE (entered the cycle after the EP byte handshake):
  - Copy all working registers to the outputs and pulse load_done for exactly one cycle.
  - Outputs hold until the next successful commit.
- Invalid byte in any parsing state:
  - Go to ERROR, set load_error=1, and leave the outputs unchanged (no partial commit).
  - ERROR drops in_ready and waits for start.
- start while busy: ignored; the parse continues.
- start in the same cycle load_done pulses: honoured next cycle (DONE accepts start).
- in_valid with in_ready low: no effect; the source must hold its data.
- Reset mid-parse: returns to IDLE immediately, and outputs take their reset values.
- Latency:
  - One byte per cycle maximum; in_ready stays high across back-to-back bytes.
  - load_done fires 1 cycle after the final EP byte is accepted.

Test Plan:
- Start, then stream the initial-position dump ("rnbqkbnr/..." as 8 lines of "r n b q k b n r" with spaces and newlines), "1111", "w", "-" -> board equals the standard start vector, castle_mask=4'b1111, white_to_move=1, en_passant_col=0, load_done one pulse 1 cycle after '-'.
- Same 64 squares with no whitespace, valid every cycle, then "0101", "b", "e" -> in_ready held high throughout, castle_mask=4'b0101, white_to_move=0, en_passant_col=4'b1100.
- Valid load A, then load B with 'x' as square 20 -> load_error=1, state ERROR, outputs still equal A, no load_done; a subsequent start clears load_error.
- Toggle in_valid randomly with gaps, and pulse start at square 30 -> start ignored, result identical to the gap-free load.
- Assert reset low at square 40 of a second load -> outputs return to the all-empty board, castle 0, white_to_move 1; after release, a full load commits correctly.
- Single white king on e1, all else '.', "0000", "w", "-" -> only the e1 field equals `WHITE_KING; all other fields equal `EMPTY_POSN.
